timer_irq_peripheral: RTL and testbench
=======================================

Name: timer_irq_peripheral

Overview:
- Memory-mapped timer peripheral on the CPU data bus.
- Responds to load/store accesses (MemRd/MemWr, word address) and raises IRQ toward the controller when the timer overflows.
- Sits beside data memory; the address decoder selects it for the 0x4000_00xx window.
- Controller masks IRQ while PCSuper is set; this block only asserts and holds the request until software clears it.

Parameters:
- BASE_ADDR, 32'h4000_0000, base of the register window.
- PRESCALE, 1, core clocks per timer tick (1 = tick every cycle); legal range 1..65535.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemRd  input  1  read strobe for the current instruction.
- MemWr  input  1  write strobe for the current instruction.
- Addr  input  32  byte address from the ALU.
- WriteData  input  32  store data.
- ReadData  output  32  load data; combinational.
- IRQ  output  1  interrupt request, level.
- Hit  output  1  Addr is within BASE_ADDR..BASE_ADDR+0x0C (word aligned); combinational.

Behaviour:
- Register map (offset, access):
  - 0x00 TH, RW: reload value.
  - 0x04 TL, RW: counter.
  - 0x08 TCON, RW: bit0 EN, bit1 IE, bit2 IS, bits31:3 read 0.
  - 0x0C SYSTICK, RO: free-running cycle count.
- Reset (reset=0, asynchronous): TH=0, TL=0, TCON=0, SYSTICK=0, prescale count=0. IRQ=0 immediately.
- Reads:
  - ReadData = selected register when MemRd & Hit, else 32'h0. Same-cycle, zero latency; single-cycle CPU samples it before the edge.
  - Misaligned Addr[1:0]!=0 or an out-of-window address gives Hit=0 and ReadData=0.
- Writes: when MemWr & Hit, the register is updated at the next rising edge.
  - Write to SYSTICK is ignored.
  - TCON write stores only bits 2:0.
  - Writing IS=0 clears a pending interrupt; writing IS=1 sets it (software trigger).
- Prescaler:
  - When EN=1, count 0..PRESCALE-1; tick is asserted in the cycle where count==PRESCALE-1, then count wraps to 0.
  - EN=0 holds count at 0.
  - PRESCALE=1 gives tick every cycle with EN=1.
- Timer, on a tick:
  - If TL==32'hFFFF_FFFF: TL<=TH, and if IE=1, IS<=1.
  - Otherwise TL<=TL+1 (32-bit, no carry out).
- Simultaneous events, same cycle:
  - CPU write to TL beats the tick: the written value is loaded and no increment happens.
  - CPU write to TCON beats the overflow's IS set, so the software clear wins. An overflow in that cycle is lost by design; documented.
  - Write to TH in the overflow cycle: reload uses the old TH.
- IRQ = IE & IS, registered-state derived. No pulse; stays high until IS or IE is cleared.
- SYSTICK increments every cycle regardless of EN and wraps at 2^32.
- MemRd and MemWr both high: the write is performed and ReadData shows the pre-write value.
- Reset mid-count clears all state asynchronously. First tick after release needs EN to be rewritten.

Decomposition:
- Shared package timer_pkg:
  - offsets TH_OFF, TL_OFF, TCON_OFF, SYSTICK_OFF.
  - TCON bit indices EN_BIT=0, IE_BIT=1, IS_BIT=2.
  - default BASE_ADDR.
- One sub-module: timer_prescaler (clk, reset, en, tick), parameterised by PRESCALE.

Test Plan:
- Reset, then read TL/TH/TCON/SYSTICK at offsets 0x04/0x00/0x08/0x0C -> values 0, 0, 0, and a small cycle count. IRQ=0 throughout reset.
- Write TH=32'hFFFF_FFF0, TL=32'hFFFF_FFFD, TCON=3 (PRESCALE=1) -> TL reads FFFF_FFFE, then FFFF_FFFF. Next cycle TL=FFFF_FFF0, TCON=7, IRQ=1.
- IRQ pending, write TCON=3 -> IRQ=0 after the edge. Counting continues from the reloaded value.
- PRESCALE=4, EN=1, TL=0 -> TL=1 after 4 cycles, TL=3 after 12 cycles.
- Write TL=5 in the same cycle as a tick, and write TCON=1 in the overflow cycle -> TL=5 and IS=0; write wins in both cases.
- Read at Addr 0x4000_0006 and 0x4000_0010 -> Hit=0, ReadData=0. Store to SYSTICK -> value unaffected. Assert reset mid-count -> all registers 0 and IRQ=0 without a clock edge.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer peripheral: register offsets, TCON bit
// positions and the default bus window.
package timer_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    localparam logic [3:0] TH_OFF      = 4'h0;
    localparam logic [3:0] TL_OFF      = 4'h4;
    localparam logic [3:0] TCON_OFF    = 4'h8;
    localparam logic [3:0] SYSTICK_OFF = 4'hC;

    localparam int unsigned EN_BIT = 0;
    localparam int unsigned IE_BIT = 1;
    localparam int unsigned IS_BIT = 2;

endpackage

// File: rtl/timer_prescaler.sv
// Divides the core clock into timer ticks; tick is high in the last cycle of
// each PRESCALE-cycle period while enabled.
module timer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] r_count;

    assign tick = en && (r_count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (!en || tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

endmodule

// File: rtl/timer_irq_peripheral.sv
// Memory-mapped reload timer with level IRQ and a free-running cycle counter,
// decoded in a 16-byte window at BASE_ADDR.
module timer_irq_peripheral
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        IRQ,
    output logic        Hit
);

    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [2:0]  r_tcon;
    logic [31:0] r_systick;

    logic [31:0] w_off;
    logic        w_hit;
    logic        w_wr_th;
    logic        w_wr_tl;
    logic        w_wr_tcon;
    logic        w_tick;
    logic        w_ovf;
    logic [31:0] w_rdata;

    assign w_off     = Addr - BASE_ADDR;
    assign w_hit     = (w_off[31:4] == 28'h0) && (w_off[1:0] == 2'b00);
    assign w_wr_th   = MemWr && w_hit && (w_off[3:0] == TH_OFF);
    assign w_wr_tl   = MemWr && w_hit && (w_off[3:0] == TL_OFF);
    assign w_wr_tcon = MemWr && w_hit && (w_off[3:0] == TCON_OFF);
    assign w_ovf     = w_tick && (r_tl == '1);

    timer_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (r_tcon[EN_BIT]),
        .tick (w_tick)
    );

    always_comb begin
        w_rdata = '0;
        if (MemRd && w_hit) begin
            case (w_off[3:0])
                TH_OFF:      w_rdata = r_th;
                TL_OFF:      w_rdata = r_tl;
                TCON_OFF:    w_rdata = {29'h0, r_tcon};
                SYSTICK_OFF: w_rdata = r_systick;
                default:     w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_th      <= '0;
            r_tl      <= '0;
            r_tcon    <= '0;
            r_systick <= '0;
        end else begin
            r_systick <= r_systick + 32'd1;
            if (w_wr_th) begin
                r_th <= WriteData;
            end
            if (w_wr_tl) begin
                r_tl <= WriteData;
            end else if (w_tick) begin
                r_tl <= w_ovf ? r_th : r_tl + 32'd1;
            end
            // A TL store swallows the whole tick, including any overflow flag.
            if (w_wr_tcon) begin
                r_tcon <= WriteData[2:0];
            end else if (w_ovf && !w_wr_tl && r_tcon[IE_BIT]) begin
                r_tcon[IS_BIT] <= 1'b1;
            end
        end
    end

    assign ReadData = w_rdata;
    assign Hit      = w_hit;
    assign IRQ      = r_tcon[IE_BIT] & r_tcon[IS_BIT];

endmodule

// File: tb/tb_timer_irq_peripheral.sv
// Directed bench for timer_irq_peripheral: a PRESCALE=1 and a PRESCALE=4
// instance share one bus; vectors plus hand sequences for timing corners.
module tb_timer_irq_peripheral;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_SYS  = 32'h4000_000C;
    localparam int NV = 24;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_hit;
        logic        exp_irq;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRd;
    logic        MemWr;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] rd1, rd4;
    logic        irq1, irq4, hit1, hit4;
    logic [31:0] tb_cycles;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    vec_t        vecs[NV];

    always #5 clk = ~clk;

    timer_irq_peripheral #(.BASE_ADDR(32'h4000_0000), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr), .Addr(Addr),
        .WriteData(WriteData), .ReadData(rd1), .IRQ(irq1), .Hit(hit1)
    );

    timer_irq_peripheral #(.BASE_ADDR(32'h4000_0000), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr), .Addr(Addr),
        .WriteData(WriteData), .ReadData(rd4), .IRQ(irq4), .Hit(hit4)
    );

    // Reference cycle count since reset release, for SYSTICK expectations.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_cycles <= '0;
        else        tb_cycles <= tb_cycles + 32'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One bus cycle: inputs change at the falling edge, outputs sampled 1ns later.
    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemRd = rd;
        MemWr = wr;
        Addr = a;
        WriteData = d;
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, A_TH,          32'h0,         32'h0,         1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, A_TL,          32'h0,         32'h0,         1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, A_TCON,        32'h0,         32'h0,         1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h4000_0006, 32'h0,         32'h0,         1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h4000_0010, 32'h0,         32'h0,         1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h3FFF_FFFC, 32'h0,         32'h0,         1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, A_TH,          32'h1234_5678, 32'h0,         1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, A_TH,          32'h0,         32'h1234_5678, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, A_TH,          32'hCAFE_F00D, 32'h1234_5678, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, A_TH,          32'h0,         32'hCAFE_F00D, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, A_TL,          32'hAAAA_5555, 32'h0,         1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, A_TL,          32'h0,         32'hAAAA_5555, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, A_TCON,        32'hFFFF_FFF8, 32'h0,         1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, A_TCON,        32'h0,         32'h0,         1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, A_TCON,        32'h6,         32'h0,         1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b0, A_TCON,        32'h0,         32'h6,         1'b1, 1'b1};
        vecs[16] = '{1'b0, 1'b1, A_TCON,        32'h2,         32'h0,         1'b1, 1'b1};
        vecs[17] = '{1'b1, 1'b0, A_TCON,        32'h0,         32'h2,         1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b1, A_TCON,        32'h4,         32'h0,         1'b1, 1'b0};
        vecs[19] = '{1'b1, 1'b0, A_TCON,        32'h0,         32'h4,         1'b1, 1'b0};
        vecs[20] = '{1'b0, 1'b1, A_TCON,        32'h0,         32'h0,         1'b1, 1'b0};
        vecs[21] = '{1'b1, 1'b0, A_TCON,        32'h0,         32'h0,         1'b1, 1'b0};
        vecs[22] = '{1'b0, 1'b1, 32'h4000_0005, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0};
        vecs[23] = '{1'b1, 1'b0, A_TL,          32'h0,         32'hAAAA_5555, 1'b1, 1'b0};

        reset = 1'b1;
        MemRd = 1'b0;
        MemWr = 1'b0;
        Addr = '0;
        WriteData = '0;
        #2 reset = 1'b0;

        repeat (2) @(negedge clk);
        MemRd = 1'b1;
        Addr = A_TL;
        #1;
        check("irq1_in_reset", 32'(irq1), 32'h0);
        check("irq4_in_reset", 32'(irq4), 32'h0);
        check("tl_in_reset", rd1, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        MemRd = 1'b0;

        drive(1'b1, 1'b0, A_SYS, 32'h0);
        check("systick_after_reset", rd1, tb_cycles);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_rdata", i), rd1, vecs[i].exp_rdata);
            check($sformatf("vec%0d_hit", i), 32'(hit1), 32'(vecs[i].exp_hit));
            check($sformatf("vec%0d_irq", i), 32'(irq1), 32'(vecs[i].exp_irq));
        end

        drive(1'b1, 1'b0, A_SYS, 32'h0);
        check("systick_before_store", rd1, tb_cycles);
        drive(1'b0, 1'b1, A_SYS, 32'h0);
        drive(1'b1, 1'b0, A_SYS, 32'h0);
        check("systick_store_ignored", rd1, tb_cycles);

        drive(1'b0, 1'b1, A_TH, 32'hFFFF_FFF0);
        drive(1'b0, 1'b1, A_TL, 32'hFFFF_FFFD);
        drive(1'b0, 1'b1, A_TCON, 32'h3);
        drive(1'b1, 1'b0, A_TL, 32'h0);
        check("ovf_tl_c1", rd1, 32'hFFFF_FFFD);
        drive(1'b1, 1'b0, A_TL, 32'h0);
        check("ovf_tl_c2", rd1, 32'hFFFF_FFFE);
        drive(1'b1, 1'b0, A_TL, 32'h0);
        check("ovf_tl_c3", rd1, 32'hFFFF_FFFF);
        check("ovf_irq_c3", 32'(irq1), 32'h0);
        drive(1'b1, 1'b0, A_TL, 32'h0);
        check("ovf_tl_reload", rd1, 32'hFFFF_FFF0);
        check("ovf_irq_set", 32'(irq1), 32'h1);
        drive(1'b1, 1'b0, A_TCON, 32'h0);
        check("ovf_tcon", rd1, 32'h7);

        drive(1'b0, 1'b1, A_TCON, 32'h3);
        check("clr_irq_pre_edge", 32'(irq1), 32'h1);
        drive(1'b1, 1'b0, A_TL, 32'h0);
        check("clr_irq_post_edge", 32'(irq1), 32'h0);
        check("clr_tl_continues", rd1, 32'hFFFF_FFF3);

        drive(1'b0, 1'b1, A_TL, 32'h5);
        drive(1'b1, 1'b0, A_TL, 32'h0);
        check("tl_write_beats_tick", rd1, 32'h5);

        drive(1'b0, 1'b1, A_TL, 32'hFFFF_FFFF);
        drive(1'b0, 1'b1, A_TCON, 32'h1);
        drive(1'b1, 1'b0, A_TCON, 32'h0);
        check("tcon_write_beats_is", rd1, 32'h1);
        check("tcon_write_irq", 32'(irq1), 32'h0);
        drive(1'b1, 1'b0, A_TL, 32'h0);
        check("tcon_write_tl_reloaded", rd1, 32'hFFFF_FFF1);

        drive(1'b0, 1'b1, A_TL, 32'hFFFF_FFFF);
        drive(1'b0, 1'b1, A_TH, 32'h0000_0100);
        drive(1'b1, 1'b0, A_TL, 32'h0);
        check("th_write_reload_old", rd1, 32'hFFFF_FFF0);
        drive(1'b1, 1'b0, A_TH, 32'h0);
        check("th_write_new", rd1, 32'h0000_0100);

        drive(1'b0, 1'b1, A_TCON, 32'h0);
        drive(1'b0, 1'b1, A_TL, 32'h0);
        drive(1'b0, 1'b1, A_TCON, 32'h1);
        for (int k = 1; k <= 13; k++) begin
            drive(1'b1, 1'b0, A_TL, 32'h0);
            check($sformatf("pre4_tl_c%0d", k), rd4, 32'((k - 1) / 4));
        end

        drive(1'b0, 1'b1, A_TCON, 32'h7);
        drive(1'b1, 1'b0, A_TCON, 32'h0);
        check("pre_reset_tcon", rd1, 32'h7);
        check("pre_reset_irq", 32'(irq1), 32'h1);
        reset = 1'b0;
        MemRd = 1'b1;
        MemWr = 1'b0;
        Addr = A_TH;
        #1;
        check("async_rst_irq1", 32'(irq1), 32'h0);
        check("async_rst_irq4", 32'(irq4), 32'h0);
        check("async_rst_th", rd1, 32'h0);
        Addr = A_TL;
        #1 check("async_rst_tl", rd1, 32'h0);
        Addr = A_TCON;
        #1 check("async_rst_tcon", rd1, 32'h0);
        Addr = A_SYS;
        #1 check("async_rst_systick", rd1, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        MemRd = 1'b0;
        drive(1'b1, 1'b0, A_TL, 32'h0);
        drive(1'b1, 1'b0, A_TL, 32'h0);
        check("post_reset_en_off", rd1, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
